// File: rtl/iob_pkg.sv
// Shared definitions for the legacy I/O bus master: FSM encoding and E clock timing.
package iob_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StVma,
        StTail,
        StRecover
    } iob_state_e;

    localparam int unsigned IOB_E_LOW    = 6;
    localparam int unsigned IOB_E_HIGH   = 4;
    localparam int unsigned IOB_E_PERIOD = IOB_E_LOW + IOB_E_HIGH;

    function automatic int unsigned e_period(input int unsigned lo, input int unsigned hi);
        return lo + hi;
    endfunction

endpackage

// File: rtl/iob_sync2.sv
// Two-flop synchroniser for asynchronous active-low bus inputs; idles (resets) to 1.
module iob_sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_q <= 1'b1;
            q_o    <= 1'b1;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/iob_master_ctl.sv
// I/O bus master: runs one 68000-style DTACK or 6800-style VPA/VMA cycle per accepted
// request from the FSB slave, with a free-running E clock and a bus-error timeout.
module iob_master_ctl
    import iob_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned E_LOW       = IOB_E_LOW,
    parameter int unsigned E_HIGH      = IOB_E_HIGH,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned RECOVER_CYC = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic IOREQ,
    input  logic IORW,
    input  logic IOL,
    input  logic IOU,
    output logic IOACT,
    output logic ALE0,
    output logic nAS,
    output logic nLDS,
    output logic nUDS,
    output logic nDoutOE,
    output logic nVMA,
    output logic E,
    input  logic nDTACK,
    input  logic nVPA,
    output logic IOBERR
);

    localparam int unsigned E_PERIOD = e_period(E_LOW, E_HIGH);

    logic       dtacks;
    logic       vpas;
    logic [7:0] ecnt_q;
    logic [7:0] ecnt_d;
    logic       e_pre_rise;
    logic [7:0] tmo_q;
    logic [7:0] tmo_inc;
    logic [7:0] phase_q;
    logic       rw_q;
    logic       l_q;
    logic       u_q;
    iob_state_e state_q;

    iob_sync2 u_sync_dtack (
        .CLK   (CLK),
        .RESET (RESET),
        .d_i   (nDTACK),
        .q_o   (dtacks)
    );

    iob_sync2 u_sync_vpa (
        .CLK   (CLK),
        .RESET (RESET),
        .d_i   (nVPA),
        .q_o   (vpas)
    );

    always_comb begin
        ecnt_d = (ecnt_q == 8'(E_PERIOD - 1)) ? 8'd0 : ecnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ecnt_q <= 8'd0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign E = (ecnt_q >= 8'(E_LOW));

    // True on the edge that moves the E counter into its last low cycle.
    assign e_pre_rise = (ecnt_d == 8'(E_LOW - 1));
    assign tmo_inc    = (tmo_q == 8'hff) ? tmo_q : tmo_q + 8'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            phase_q <= 8'd0;
            tmo_q   <= 8'd0;
            rw_q    <= 1'b0;
            l_q     <= 1'b0;
            u_q     <= 1'b0;
            IOACT   <= 1'b0;
            ALE0    <= 1'b0;
            IOBERR  <= 1'b0;
            nAS     <= 1'b1;
            nLDS    <= 1'b1;
            nUDS    <= 1'b1;
            nDoutOE <= 1'b1;
            nVMA    <= 1'b1;
        end else begin
            ALE0   <= 1'b0;
            IOBERR <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (IOREQ) begin
                        state_q <= StSetup;
                        phase_q <= 8'd0;
                        IOACT   <= 1'b1;
                        ALE0    <= 1'b1;
                        rw_q    <= IORW;
                        l_q     <= IOL;
                        u_q     <= IOU;
                    end
                end
                StSetup: begin
                    if (phase_q == 8'(SETUP_CYC - 1)) begin
                        state_q <= StStrobe;
                        nAS     <= 1'b0;
                        tmo_q   <= 8'd0;
                        if (rw_q) begin
                            nLDS <= ~l_q;
                            nUDS <= ~u_q;
                        end else begin
                            nDoutOE <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                StStrobe: begin
                    state_q <= StWait;
                    // Writes give the data one cycle on the bus before the strobes.
                    if (!rw_q) begin
                        nLDS <= ~l_q;
                        nUDS <= ~u_q;
                    end
                end
                StWait: begin
                    tmo_q <= tmo_inc;
                    if (!dtacks) begin
                        state_q <= StTail;
                        nAS     <= 1'b1;
                        nLDS    <= 1'b1;
                        nUDS    <= 1'b1;
                    end else if (!vpas) begin
                        state_q <= StVma;
                        nVMA    <= ~e_pre_rise;
                    end else if (tmo_inc == 8'(TIMEOUT_CYC)) begin
                        state_q <= StTail;
                        IOBERR  <= 1'b1;
                        nAS     <= 1'b1;
                        nLDS    <= 1'b1;
                        nUDS    <= 1'b1;
                    end
                end
                StVma: begin
                    // Once VMA is out, finish on the edge where E falls.
                    if (!nVMA && ecnt_q == 8'(E_PERIOD - 1)) begin
                        state_q <= StTail;
                        nAS     <= 1'b1;
                        nLDS    <= 1'b1;
                        nUDS    <= 1'b1;
                        nVMA    <= 1'b1;
                    end else if (nVMA && e_pre_rise) begin
                        nVMA <= 1'b0;
                    end
                end
                StTail: begin
                    state_q <= StRecover;
                    phase_q <= 8'd0;
                    nDoutOE <= 1'b1;
                    IOACT   <= 1'b0;
                end
                StRecover: begin
                    if (phase_q == 8'(RECOVER_CYC - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_master_ctl.sv
// Scoreboard bench for iob_master_ctl: stimulus queues expected output-vector changes,
// a negedge monitor pops and compares them as the bus outputs change.
module tb_iob_master_ctl;

    localparam int E_PER   = 10;
    localparam int E_LO    = 6;
    localparam logic [7:0] IDLE_V = 8'h3e;

    localparam int TDTACK = 0;
    localparam int TVPA   = 1;
    localparam int TBOTH  = 2;
    localparam int TTMO   = 3;
    localparam int TRST   = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic IOREQ, IORW, IOL, IOU;
    logic IOACT, ALE0, nAS, nLDS, nUDS, nDoutOE, nVMA, E, IOBERR;
    logic nDTACK, nVPA;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_exp;
    logic [7:0] prev_v;
    int         cyc = 0;
    int         e_model = 0;
    int         r_edge = 0;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;

    iob_master_ctl dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IOREQ   (IOREQ),
        .IORW    (IORW),
        .IOL     (IOL),
        .IOU     (IOU),
        .IOACT   (IOACT),
        .ALE0    (ALE0),
        .nAS     (nAS),
        .nLDS    (nLDS),
        .nUDS    (nUDS),
        .nDoutOE (nDoutOE),
        .nVMA    (nVMA),
        .E       (E),
        .nDTACK  (nDTACK),
        .nVPA    (nVPA),
        .IOBERR  (IOBERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        e_model <= RESET ? 0 : ((e_model == E_PER - 1) ? 0 : e_model + 1);
    end

    function automatic logic [7:0] mk(input logic act, ale, nas, nlds, nuds, noe, nvma, berr);
        return {act, ale, nas, nlds, nuds, noe, nvma, berr};
    endfunction

    function automatic logic [7:0] outv();
        return {IOACT, ALE0, nAS, nLDS, nUDS, nDoutOE, nVMA, IOBERR};
    endfunction

    // Monitor: every change of the strobe/handshake vector must match the next expected entry.
    always @(negedge CLK) begin
        logic [7:0] cur;
        exp_t       e;
        cur = outv();
        if (mon_en && cur !== prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%b (none queued)", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec !== cur) begin
                    failures++;
                    $display("FAIL bus_vector got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                             cyc, cur, e.cyc, e.vec);
                end
            end
            checks++;
            if (E !== (e_model >= E_LO)) begin
                failures++;
                $display("FAIL e_clock cyc=%0d got=%b expected=%b", cyc, E, (e_model >= E_LO));
            end
        end
        prev_v = cur;
    end

    task automatic exp_push(input int c, input logic [7:0] v);
        exp_t e;
        if (v !== last_exp) begin
            e.cyc = c;
            e.vec = v;
            exp_q.push_back(e);
            last_exp = v;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // s is the edge that samples IOREQ (ALE0 edge); t_end returns the TAIL (or reset) edge.
    task automatic run_cycle(input logic rw, input logic l, input logic u, input int term,
                             input int k, input bit hold, input int s, output int t_end);
        logic noe;
        int   p, n, t;
        IORW  = rw;
        IOL   = l;
        IOU   = u;
        IOREQ = 1'b1;
        noe   = rw ? 1'b1 : 1'b0;
        exp_push(s,     mk(1, 1, 1, 1, 1, 1, 1, 0));
        exp_push(s + 1, mk(1, 0, 1, 1, 1, 1, 1, 0));
        if (rw) begin
            exp_push(s + 2, mk(1, 0, 0, ~l, ~u, 1, 1, 0));
        end else begin
            exp_push(s + 2, mk(1, 0, 0, 1, 1, 0, 1, 0));
            exp_push(s + 3, mk(1, 0, 0, ~l, ~u, 0, 1, 0));
        end
        p = s + 2 + k;
        t = p + 3;
        if (term == TVPA) begin
            n = p + 3;
            while (((n - r_edge) % E_PER) != E_LO - 1) n++;
            exp_push(n, mk(1, 0, 0, ~l, ~u, noe, 0, 0));
            t = n + 5;
        end else if (term == TTMO) begin
            t = s + 258;
        end else if (term == TRST) begin
            t = p + 1;
        end
        if (term == TRST) begin
            exp_push(t, IDLE_V);
        end else begin
            exp_push(t, mk(1, 0, 1, 1, 1, noe, 1, (term == TTMO)));
            exp_push(t + 1, IDLE_V);
        end

        wait_cyc(s);
        if (!hold) IOREQ = 1'b0;
        IORW = ~rw;
        IOL  = ~l;
        IOU  = ~u;
        if (term != TTMO) begin
            wait_cyc(p);
            if (term == TDTACK || term == TBOTH) nDTACK = 1'b0;
            if (term == TVPA || term == TBOTH) nVPA = 1'b0;
            if (term == TRST) RESET = 1'b1;
        end
        wait_cyc(t);
        nDTACK = 1'b1;
        nVPA   = 1'b1;
        if (term == TRST) begin
            RESET  = 1'b0;
            r_edge = t;
            checks++;
            if (E !== 1'b0 || IOBERR !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_cycle E=%b IOBERR=%b expected 0 0", E, IOBERR);
            end
        end else begin
            wait_cyc(t + 1);
        end
        t_end = t;
    endtask

    initial begin
        int t1, t2;
        RESET    = 1'b1;
        IOREQ    = 1'b0;
        IORW     = 1'b0;
        IOL      = 1'b0;
        IOU      = 1'b0;
        nDTACK   = 1'b1;
        nVPA     = 1'b1;
        last_exp = IDLE_V;
        @(negedge CLK);
        wait_cyc(3);
        RESET  = 1'b0;
        r_edge = 3;
        checks++;
        if (outv() !== IDLE_V || E !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%b E=%b expected=%b E=0", outv(), E, IDLE_V);
        end
        mon_en = 1'b1;
        wait_cyc(cyc + 2);

        run_cycle(1'b1, 1'b1, 1'b1, TDTACK, 4, 1'b0, cyc + 1, t1);   // word read
        wait_cyc(cyc + 3);
        run_cycle(1'b0, 1'b1, 1'b0, TDTACK, 2, 1'b0, cyc + 1, t1);   // lower byte write
        wait_cyc(cyc + 3);
        run_cycle(1'b1, 1'b1, 1'b1, TVPA, 1, 1'b0, cyc + 1, t1);     // VPA read
        wait_cyc(cyc + 2);
        run_cycle(1'b0, 1'b1, 1'b1, TBOTH, 3, 1'b0, cyc + 1, t1);    // DTACK beats VPA
        wait_cyc(cyc + 4);
        run_cycle(1'b1, 1'b0, 1'b0, TDTACK, 0, 1'b0, cyc + 1, t1);   // no byte strobes
        wait_cyc(cyc + 3);
        run_cycle(1'b1, 1'b0, 1'b1, TTMO, 0, 1'b0, cyc + 1, t1);     // bus error timeout
        wait_cyc(cyc + 3);
        run_cycle(1'b1, 1'b1, 1'b0, TDTACK, 1, 1'b1, cyc + 1, t1);   // back-to-back, first
        run_cycle(1'b0, 1'b0, 1'b1, TVPA, 5, 1'b0, t1 + 3, t2);      // back-to-back, second
        wait_cyc(cyc + 3);
        run_cycle(1'b1, 1'b1, 1'b1, TRST, 8, 1'b0, cyc + 1, t1);     // reset mid-WAIT
        wait_cyc(cyc + 2);
        run_cycle(1'b0, 1'b1, 1'b1, TDTACK, 3, 1'b0, cyc + 1, t1);   // recovery after reset
        wait_cyc(cyc + 20);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain remaining=%0d expected=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob_master_ctl.md
Name: iob_master_ctl

Overview:
- Downstream stage of the I/O bus FSB slave: consumes its one-deep request (IOREQ, IORW0, IOL0, IOU0) and runs one 68000-style cycle on the legacy I/O bus.
- Covers both DTACK cycles and 6800-style VPA/VMA cycles synchronised to a locally generated E clock.
- Reports progress back through IOACT.
- Enforces a bus-error timeout so a missing peripheral cannot hang the CPU.

Parameters:
- SETUP_CYC, 2, CLK cycles from ALE0 to nAS assert (address setup)
- E_LOW, 6, CLK cycles E is low per E period
- E_HIGH, 4, CLK cycles E is high per E period
- TIMEOUT_CYC, 255, CLK cycles in WAIT before bus error; 8-bit counter
- RECOVER_CYC, 1, idle CLK cycles after strobes negate before the next cycle may start

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- IOREQ  in  1  request from FSB slave FIFO primary level
- IORW  in  1  1 = read, 0 = write (from IORW0)
- IOL  in  1  lower byte strobe request (from IOL0)
- IOU  in  1  upper byte strobe request (from IOU0)
- IOACT  out  1  cycle accepted/in progress
- ALE0  out  1  one-cycle pulse: latch address/write data into the I/O-side register
- nAS  out  1  I/O bus address strobe
- nLDS  out  1  I/O bus lower data strobe
- nUDS  out  1  I/O bus upper data strobe
- nDoutOE  out  1  write-data output enable to the I/O bus
- nVMA  out  1  6800 valid memory address
- E  out  1  6800 E clock
- nDTACK  in  1  async, active low
- nVPA  in  1  async, active low
- IOBERR  out  1  one-cycle pulse: bus error on timeout

Behaviour:
- Reset values:
  - IOACT=0, ALE0=0, IOBERR=0, E=0.
  - nAS, nLDS, nUDS, nDoutOE, nVMA all 1.
  - State IDLE; E counter 0; timeout counter 0.
- Input synchronisation:
  - nDTACK and nVPA pass through two-flop synchronisers (reset to 1).
  - Only the synced versions (DTACKs, VPAs) are used.
- E generator:
  - Free-running mod-(E_LOW+E_HIGH) counter.
  - E=1 when count >= E_LOW.
  - Unaffected by the FSM; reset only by RESET.
- FSM states: IDLE, SETUP, STROBE, WAIT, VMA, TAIL, RECOVER.
- IDLE: IOREQ=1 sampled -> SETUP.
  - Same edge: IOACT<=1, ALE0<=1 for exactly one cycle.
  - Same edge: IORW/IOL/IOU captured into internal registers; later changes on IORW/IOL/IOU are ignored.
- SETUP: hold SETUP_CYC cycles, then STROBE.
- STROBE: nAS<=0 and timeout counter cleared.
  - Read: nLDS<=~IOL and nUDS<=~IOU on the same edge.
  - Write: nDoutOE<=0 on the same edge; data strobes assert one cycle later, in WAIT.
  - Then -> WAIT.
- WAIT: timeout counter increments each cycle. Exits, in priority order:
  1. DTACKs=0 -> TAIL.
  2. VPAs=0 -> VMA; nVMA asserts on the first cycle where E counter == E_LOW-1 (E about to rise).
  3. Counter == TIMEOUT_CYC -> TAIL with IOBERR pulse.
- VMA: wait for the E falling edge (counter wraps to 0), then -> TAIL.
- TAIL: nAS, nLDS, nUDS, nVMA negate on entry edge; nDoutOE negates one cycle later. -> RECOVER.
- RECOVER: IOACT<=0 on entry; hold RECOVER_CYC cycles, then -> IDLE.
- IOACT handshake:
  - Rises on the edge after IOREQ is sampled.
  - Stays high for the whole cycle and falls only in RECOVER.
  - Upstream drops IOREQ after seeing IOACT and issues a new IOREQ only after seeing IOACT low.
  - An IOREQ still high at return to IDLE starts a new cycle (back-to-back allowed).
- Boundaries:
  - DTACK and VPA both asserted: DTACK wins.
  - IOL=IOU=0: full cycle runs with no data strobes; it terminates via DTACK/VPA or the timeout.
  - RESET mid-cycle: all strobes negate on the next edge and IOACT drops; no IOBERR.
  - Timeout counter saturates and never wraps.

Decomposition:
- Shared package iob_pkg:
  - FSM state encoding.
  - E-period constant (E_LOW+E_HIGH).
- One sub-module: iob_sync2, a two-flop synchroniser with reset-to-1, instanced for nDTACK and nVPA.
- E generator and FSM stay in iob_master_ctl.

Test Plan:
- Word read:
  - Stimulus: IOREQ=1, IORW=1, IOL=IOU=1 at t0; nDTACK low 4 cycles after nAS.
  - Required: ALE0 pulse at t0+1; nAS/nLDS/nUDS low at t0+1+SETUP_CYC.
  - Required: strobes negate 2 sync cycles after DTACK; IOACT low in RECOVER.
- Byte write:
  - Stimulus: IORW=0, IOL=1, IOU=0.
  - Required: nDoutOE asserts with nAS; nLDS asserts one cycle later; nUDS stays 1 throughout.
  - Required: nDoutOE negates one cycle after nAS.
- VPA cycle:
  - Stimulus: nVPA low, nDTACK high.
  - Required: nVMA asserts only just before E rises; TAIL entered at E fall; IOBERR=0.
- Timeout:
  - Stimulus: no DTACK/VPA with TIMEOUT_CYC=255.
  - Required: one-cycle IOBERR pulse exactly 255 cycles into WAIT; strobes negate; IOACT falls.
- Back-to-back:
  - Stimulus: IOREQ held high across two requests.
  - Required: second ALE0 pulse exactly RECOVER_CYC+1 cycles after IOACT falls; no overlap of nAS.
- Reset mid-WAIT:
  - Stimulus: RESET=1 while nAS low.
  - Required: next edge has all strobes 1, IOACT=0, IOBERR=0; E restarts at 0.
